// File: rtl/line_fill_responder.sv
// line_fill_responder: serves 4-word cache line fills from a local word store after a fixed latency.
// Build option: define CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module line_fill_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic        abort,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic [1:0]  o_word,
  output logic        o_last
);

  // state   | meaning
  // S_IDLE  | no fill in flight, request may be accepted
  // S_WAIT  | access latency counting down
  // S_BURST | one beat per edge; the edge after the last beat returns to idle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  localparam int         DEPTH        = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD     = 4'(LATENCY - 1);
  localparam bit         DIRECT_BURST = (LATENCY == 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] line_q, line_d;
  logic [1:0]  crit_q, crit_d;
  logic [1:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        o_valid_q, o_valid_d;
  logic        o_last_q, o_last_d;
  logic [1:0]  o_word_q, o_word_d;
  logic [15:0] o_data_q, o_data_d;

  logic [15:0]           mem [DEPTH];
  logic [1:0]            base;
  logic [1:0]            rd_off;
  logic [15:0]           rd_full;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  unused_bits;

`ifdef CRITICAL_WORD_FIRST_EN
  assign base        = crit_q;
  assign unused_bits = ^{rd_full, wr_addr};
`else
  assign base        = 2'd0;
  assign unused_bits = ^{rd_full, wr_addr, crit_q};
`endif

  // Upper address bits beyond the store size are dropped here.
  assign rd_off  = base + beat_q;
  assign rd_full = {line_q, rd_off};
  assign rd_idx  = rd_full[ADDR_WIDTH-1:0];
  assign wr_idx  = wr_addr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    crit_d    = crit_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    o_valid_d = 1'b0;
    o_last_d  = 1'b0;
    o_word_d  = o_word_q;
    o_data_d  = o_data_q;

    case (state_q)
      S_IDLE: begin
        if (req && !abort) begin
          line_d = req_addr[15:2];
          crit_d = req_addr[1:0];
          beat_d = 2'd0;
          busy_d = 1'b1;
          if (DIRECT_BURST) begin
            state_d = S_BURST;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (abort || o_last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          // Store read happens before any same-edge write lands.
          o_valid_d = 1'b1;
          o_word_d  = rd_off;
          o_data_d  = mem[rd_idx];
          o_last_d  = (beat_q == 2'd3);
          beat_d    = beat_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      line_q    <= 14'd0;
      crit_q    <= 2'd0;
      beat_q    <= 2'd0;
      busy_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_word_q  <= 2'd0;
      o_data_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      crit_q    <= crit_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_word_q  <= o_word_d;
      o_data_q  <= o_data_d;
    end
  end

  assign busy    = busy_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_word  = o_word_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: two instances (LATENCY 2 and 1) against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_line_fill_responder;
  localparam int MEM = 1024;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic        abort = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = 16'h0;
  logic [15:0] wr_data = 16'h0;

  logic        busy0, o_valid0, o_last0;
  logic [1:0]  o_word0;
  logic [15:0] o_data0;
  logic        busy1, o_valid1, o_last1;
  logic [1:0]  o_word1;
  logic [15:0] o_data1;

  always #5 clk = ~clk;

  line_fill_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
    .clk(clk), .reset(rst), .req(req), .req_addr(req_addr), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy0), .o_data(o_data0), .o_valid(o_valid0), .o_word(o_word0), .o_last(o_last0));

  line_fill_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .req(req), .req_addr(req_addr), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy1), .o_data(o_data1), .o_valid(o_valid1), .o_word(o_word1), .o_last(o_last1));

  // Reference model: a fill accepted at edge t delivers beat k at edge t+LAT+k, k=0..3.
  logic [15:0] mm [MEM];
  int          cyc = 0;
  logic        m_busy [2];
  logic        m_valid [2];
  logic        m_last [2];
  logic [1:0]  m_word [2];
  logic [15:0] m_data [2];
  int          m_acc [2];
  int          m_line [2];
  int          m_crit [2];
  int          mk, mbase, moff;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_last[i] = 1'b0;
        m_word[i] = 2'd0; m_data[i] = 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0;
        m_last[i]  = 1'b0;
        if (m_busy[i]) begin
          mk = cyc - m_acc[i] - lat_of(i);
          mbase = CWF ? m_crit[i] : 0;
          if (abort) m_busy[i] = 1'b0;
          else if (mk >= 0 && mk <= 3) begin
            moff = (mbase + mk) % 4;
            m_valid[i] = 1'b1;
            m_last[i]  = (mk == 3);
            m_word[i]  = 2'(moff);
            m_data[i]  = mm[(m_line[i] * 4 + moff) % MEM];
          end else if (mk == 4) m_busy[i] = 1'b0;
        end else if (req && !abort) begin
          m_busy[i] = 1'b1;
          m_acc[i]  = cyc;
          m_line[i] = int'(req_addr) / 4;
          m_crit[i] = int'(req_addr) % 4;
        end
      end
      if (wr_en) mm[int'(wr_addr) % MEM] = wr_data;
      cyc++;
    end
  end

  wire [20:0] got0 = {busy0, o_valid0, o_last0, o_word0, o_data0};
  wire [20:0] got1 = {busy1, o_valid1, o_last1, o_word1, o_data1};
  wire [20:0] exp0 = {m_busy[0], m_valid[0], m_last[0], m_word[0], m_data[0]};
  wire [20:0] exp1 = {m_busy[1], m_valid[1], m_last[1], m_word[1], m_data[1]};

  task automatic drive(input logic r, input logic [15:0] a, input logic ab,
                       input logic we, input logic [15:0] wa, input logic [15:0] wd);
    @(negedge clk);
    req = r; req_addr = a; abort = ab; wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic preload();
    for (int a = 0; a < MEM; a++) drive(1'b0, 16'h0, 1'b0, 1'b1, 16'(a), 16'($urandom));
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (got0 !== 21'h0) $display("FAIL reset_l2 got=%h exp=%h", got0, 21'h0); else n_pass++;
    n_total++;
    if (got1 !== 21'h0) $display("FAIL reset_l1 got=%h exp=%h", got1, 21'h0); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (got0 !== exp0) $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, got0, exp0); else n_pass++;
    preload();
  endtask

  task automatic test_basic_fill();
    logic [15:0] a [4];
    logic [1:0]  ew;
    int          k = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'hA000 | 16'($urandom_range(0, 4095));
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010 + 16'(i), a[i]);
    end
    drive(1'b1, 16'h0012, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL fill_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL fill_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
      n_total++;
      if (o_valid0 !== (c >= 2 && c <= 5)) $display("FAIL fill_valid c=%0d got=%0b", c, o_valid0); else n_pass++;
      if (o_valid0 === 1'b1) begin
        ew = CWF ? 2'(2 + k) : 2'(k);
        n_total++;
        if ({o_word0, o_data0, o_last0} !== {ew, a[ew], (k == 3)})
          $display("FAIL fill_beat k=%0d got=%h/%h/%0b exp=%h/%h/%0b", k, o_word0, o_data0, o_last0, ew, a[ew], (k == 3));
        else n_pass++;
        k++;
      end
      idle();
    end
    n_total++;
    if (k !== 4) $display("FAIL fill_beats got=%0d exp=4", k); else n_pass++;
  endtask

  task automatic test_abort();
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL abort_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL abort_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
      if (c == 4) begin
        n_total++;
        if ({busy0, o_valid0, o_last0} !== 3'b000) $display("FAIL abort_clear got=%b exp=000", {busy0, o_valid0, o_last0});
        else n_pass++;
      end
      if (c == 3) drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
      else idle();
    end
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL after_abort_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL after_abort_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
      idle();
    end
  endtask

  task automatic test_write_race();
    logic [15:0] old1;
    old1 = mm[16'h0011];
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        n_total++;
        if (got0 !== exp0) $display("FAIL race_l2 p=%0d c=%0d got=%h exp=%h", pass, c, got0, exp0); else n_pass++;
        n_total++;
        if (got1 !== exp1) $display("FAIL race_l1 p=%0d c=%0d got=%h exp=%h", pass, c, got1, exp1); else n_pass++;
        if (c == 3) begin
          n_total++;
          if ({o_valid0, o_word0, o_data0} !== {1'b1, 2'd1, (pass == 0) ? old1 : 16'hBEEF})
            $display("FAIL race_beat1 p=%0d got=%h exp=%h", pass, o_data0, (pass == 0) ? old1 : 16'hBEEF);
          else n_pass++;
        end
        if (pass == 0 && c == 2) drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0011, 16'hBEEF);
        else idle();
      end
    end
  endtask

  task automatic test_ignored_req_reset();
    int beats = 0;
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL ignore_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL ignore_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
      if (o_valid0 === 1'b1) beats++;
      if (c < 4) drive(1'b1, 16'h0080, 1'b0, 1'b0, 16'h0, 16'h0);
      else idle();
    end
    n_total++;
    if (beats !== 4) $display("FAIL ignore_beats got=%0d exp=4", beats); else n_pass++;

    drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (got0 !== 21'h0) $display("FAIL async_reset_l2 got=%h exp=%h", got0, 21'h0); else n_pass++;
    n_total++;
    if (got1 !== 21'h0) $display("FAIL async_reset_l1 got=%h exp=%h", got1, 21'h0); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL retain_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL retain_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
      idle();
    end
  endtask

  task automatic test_latency1();
    logic [15:0] addrs [2];
    int          k;
    addrs[0] = 16'h03FC;
    addrs[1] = 16'hFFFC;
    for (int f = 0; f < 2; f++) begin
      k = 0;
      drive(1'b1, addrs[f], 1'b0, 1'b0, 16'h0, 16'h0);
      for (int c = 0; c < 7; c++) begin
        @(posedge clk); #1;
        n_total++;
        if (got1 !== exp1) $display("FAIL lat1_model f=%0d c=%0d got=%h exp=%h", f, c, got1, exp1); else n_pass++;
        n_total++;
        if (got0 !== exp0) $display("FAIL lat1_l2 f=%0d c=%0d got=%h exp=%h", f, c, got0, exp0); else n_pass++;
        n_total++;
        if (o_valid1 !== (c >= 1 && c <= 4)) $display("FAIL lat1_valid f=%0d c=%0d got=%0b", f, c, o_valid1); else n_pass++;
        if (o_valid1 === 1'b1) begin
          n_total++;
          if ({o_word1, o_data1} !== {2'(k), mm[16'h03FC + k]})
            $display("FAIL lat1_beat f=%0d k=%0d got=%h/%h exp=%h/%h", f, k, o_word1, o_data1, 2'(k), mm[16'h03FC + k]);
          else n_pass++;
          k++;
        end
        idle();
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 3) == 0, {6'($urandom), 4'h0, 6'($urandom)}, ($urandom % 20) == 0,
            ($urandom % 4) == 0, {6'($urandom), 4'h0, 6'($urandom)}, 16'($urandom));
      @(posedge clk); #1;
      n_total++;
      if (got0 !== exp0) $display("FAIL rand_l2 c=%0d got=%h exp=%h", c, got0, exp0); else n_pass++;
      n_total++;
      if (got1 !== exp1) $display("FAIL rand_l1 c=%0d got=%h exp=%h", c, got1, exp1); else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_abort();
    test_write_race();
    test_ignored_req_reset();
    test_latency1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder for cache line fills. Accepts a line read request (16-bit word address) from an instruction or data cache.
- After a programmable access latency, returns the 4-word line one word per cycle.
- Holds the backing word store, which has a direct load/write port for bench preload and for store traffic.
- Sits between the cache miss FSMs and the memory model; it is the serving end of the cache refill interface.

Parameters:
- ADDR_WIDTH, 10, word-address bits indexing the store (2^ADDR_WIDTH 16-bit words); upper request bits ignored
- LATENCY, 2, cycles from request acceptance to first data beat; legal range 1..15

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  line read request, sampled only when busy=0
- req_addr  input  16  requested word address; [15:2] line, [1:0] requested word
- abort  input  1  synchronous cancel of the in-flight fill (pipeline flush)
- wr_en  input  1  store write enable
- wr_addr  input  16  store write word address
- wr_data  input  16  store write data
- busy  output  1  request accepted and fill not finished
- o_data  output  16  returned word, registered
- o_valid  output  1  o_data/o_word valid this cycle
- o_word  output  2  word offset within the line of o_data
- o_last  output  1  final beat of the line

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE, busy=0, o_valid=0, o_last=0, o_word=0, o_data=16'h0000, latency counter=0. Store contents are not cleared.
- States:
  - IDLE: on req && !abort at edge N, latch line=req_addr[15:2] and crit=req_addr[1:0], load counter=LATENCY-1, go to WAIT (or BURST directly if LATENCY=1). busy=1 from cycle N+1.
  - WAIT: counter decrements each edge; at 0 go to BURST.
  - BURST: 4 beats on 4 consecutive edges. The first o_valid=1 is visible in the cycle after edge N+LATENCY.
- Beat order: beat k returns offset (base+k) mod 4. base=0 by default (see Optional Feature). Offset wraps 3->0.
- Store index: {line, offset} truncated to ADDR_WIDTH low bits.
- Read timing: o_data is the store content sampled at the edge that issues the beat. A wr_en at that same edge is not visible; a write at an earlier edge is visible, even if issued mid-fill.
- o_last=1 with the 4th beat only. At the edge after the last beat: o_valid=0, o_last=0, busy=0, state IDLE. A req is accepted no earlier than the cycle where busy=0 (back-to-back fills have 1 idle cycle min).
- o_data holds its last value while o_valid=0; o_word is likewise stable.
- req while busy=1: ignored, not queued.
- abort=1 in WAIT or BURST: next edge → IDLE, busy=0, o_valid=0, o_last=0. Remaining beats are discarded.
- abort in IDLE: no effect. abort with req in the same IDLE cycle: request not accepted.
- Writes: wr_en writes wr_data to the store at the edge, in any state, independent of fills.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: base=crit, so beats return crit, crit+1, … wrapping mod 4; o_word tells the cache where each word goes. o_last still marks the 4th beat.
- Undefined: base=0, beats are always offsets 0,1,2,3, and crit is latched but unused.

Test Plan:
- Reset/basic fill:
  - Stimulus: preload store[0x10..0x13]=A0,A1,A2,A3; LATENCY=2; req with req_addr=0x0012 at cycle 0.
  - Response: busy from cycle 1; o_valid in cycles 2–5 with o_word 0,1,2,3 and data A0..A3; o_last in cycle 5; busy=0 in cycle 6.
- Critical word first (macro defined):
  - Stimulus: same preload and request as above.
  - Response: beats o_word 2,3,0,1 with data A2,A3,A0,A1; o_last on A1.
- Abort mid-burst:
  - Stimulus: abort asserted during the 2nd beat.
  - Response: next cycle o_valid=0 and busy=0; a new req at 0x0020 then completes normally.
- Write/read race:
  - Stimulus: wr_en to 0x11 with 0xBEEF at the edge that issues beat 1, then a repeated fill.
  - Response: beat 1 returns the old A1; the second fill returns 0xBEEF.
- Ignored request and async reset:
  - Stimulus: req while busy; then reset asserted mid-WAIT.
  - Response: the req while busy causes no extra beats. The mid-WAIT reset immediately clears busy, o_valid, o_last and o_data to 0, and the store retains its data.
- LATENCY=1 boundary:
  - Stimulus: LATENCY=1; req at 0x03FC with ADDR_WIDTH=10.
  - Response: first beat in cycle 1; indices 0x3FC..0x3FF; address bits above 9 ignored (0xFFFC maps to the same line).
